alu_seq_unit: RTL and testbench

Execute-stage arithmetic unit that consumes the 3-bit ALUControl code from the ALU decoder and the SrcA/SrcB operands, and produces ALUResult and Zero for the datapath. AND, OR, ADD, SUB and SLT resolve combinationally in one cycle. MUL runs on an iterative shift-add engine over 32 cycles, and the unit asserts Stall so the control path freezes the PC and register-file writes until the product is ready.

---
 rtl/alu_seq_unit.sv | 134 +++++++++++++
 tb/tb_alu_seq_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_unit
// Brief    : Execute-stage ALU; single-cycle logic/arith ops, 32-cycle
//            shift-add multiply with pipeline stall.
// Revision : 1.0  initial release
// ============================================================================
module alu_seq_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  input  logic [2:0]            ALUControl,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero,
  output logic                  Stall,
  output logic                  MulDone
);

  localparam int c_cw = $clog2(DATA_WIDTH);
  localparam logic [c_cw-1:0] c_last = c_cw'(DATA_WIDTH - 1);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_busy = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  localparam logic [2:0] c_op_and = 3'b000;
  localparam logic [2:0] c_op_or  = 3'b001;
  localparam logic [2:0] c_op_add = 3'b010;
  localparam logic [2:0] c_op_sub = 3'b100;
  localparam logic [2:0] c_op_slt = 3'b110;
  localparam logic [2:0] c_op_mul = 3'b101;

  logic [1:0]            r_state;
  logic [1:0]            w_next;
  logic [DATA_WIDTH-1:0] r_mcand;
  logic [DATA_WIDTH-1:0] r_mplr;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [c_cw-1:0]       r_count;
  logic [DATA_WIDTH-1:0] w_alu;
  logic                  w_slt;
  logic                  w_issue;

  assign w_issue = (ALUControl == c_op_mul);
  assign w_slt   = ($signed(SrcA) < $signed(SrcB));

  always_comb begin
    w_alu = '0;
    case (ALUControl)
      c_op_and: w_alu = SrcA & SrcB;
      c_op_or:  w_alu = SrcA | SrcB;
      c_op_add: w_alu = SrcA + SrcB;
      c_op_sub: w_alu = SrcA - SrcB;
      c_op_slt: w_alu = {{(DATA_WIDTH-1){1'b0}}, w_slt};
      default:  w_alu = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle:  if (w_issue) w_next = c_busy;
      c_busy:  if (r_count == c_last) w_next = c_done;
      c_done:  w_next = c_idle;
      default: w_next = c_idle;
    endcase
  end

  // Operands are captured at issue so the datapath may move on during BUSY.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_mcand <= '0;
      r_mplr  <= '0;
      r_acc   <= '0;
      r_count <= '0;
    end else if (r_state == c_idle) begin
      if (w_issue) begin
        r_mcand <= SrcA;
        r_mplr  <= SrcB;
        r_acc   <= '0;
        r_count <= '0;
      end
    end else if (r_state == c_busy) begin
      if (r_mplr[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand <= r_mcand << 1;
      r_mplr  <= r_mplr >> 1;
      r_count <= r_count + c_cw'(1);
    end
  end

  always_comb begin
    ALUResult = w_alu;
    Zero      = (w_alu == '0);
    Stall     = 1'b0;
    MulDone   = 1'b0;
    case (r_state)
      c_idle: begin
        if (w_issue) begin
          ALUResult = '0;
          Zero      = 1'b0;
          Stall     = ~RST;
        end
      end
      c_busy: begin
        ALUResult = '0;
        Zero      = 1'b0;
        Stall     = 1'b1;
      end
      c_done: begin
        ALUResult = r_acc;
        Zero      = (r_acc == '0);
        MulDone   = 1'b1;
      end
      default: begin
        ALUResult = w_alu;
        Zero      = (w_alu == '0);
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq_unit
// Brief    : Scoreboard bench for alu_seq_unit.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_seq_unit;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [2:0]  aluctl;
  logic [31:0] aluresult;
  logic        zero;
  logic        stall;
  logic        muldone;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  exp_t sb[$];

  alu_seq_unit #(.DATA_WIDTH(32)) dut (
    .CLK        (clk),
    .RST        (rst),
    .SrcA       (srca),
    .SrcB       (srcb),
    .ALUControl (aluctl),
    .ALUResult  (aluresult),
    .Zero       (zero),
    .Stall      (stall),
    .MulDone    (muldone)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b100:  return a - b;
      3'b110:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b101:  return a * b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic push_exp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.res  = model(op, a, b);
    e.zero = (e.res == 32'd0);
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_res"}, aluresult, e.res);
      check({tag, "_zero"}, {31'd0, zero}, {31'd0, e.zero});
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    srca = a; srcb = b; aluctl = op;
    push_exp(op, a, b);
    @(negedge clk);
    pop_check(tag);
    check({tag, "_stall"}, {31'd0, stall}, 32'd0);
  endtask

  task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble, output int done_at);
    int n;
    int bad;
    bit seen;
    @(posedge clk); #1;
    srca = a; srcb = b; aluctl = 3'b101;
    push_exp(3'b101, a, b);
    @(negedge clk);
    check({tag, "_issue_stall"}, {31'd0, stall}, 32'd1);
    check({tag, "_issue_res"}, {aluresult[31:1], zero | aluresult[0]}, 32'd0);
    n = 0; bad = 0; seen = 0; done_at = -1;
    while (n < 40 && !seen) begin
      if (scramble && n == 0) begin
        @(posedge clk); #1;
        srca = 32'd99; srcb = 32'd99; aluctl = 3'b010;
      end
      @(negedge clk);
      n++;
      if (muldone) begin
        seen = 1;
      end else if (stall !== 1'b1 || zero !== 1'b0 || aluresult !== 32'd0) begin
        bad++;
      end
    end
    check({tag, "_busy_flags"}, bad, 0);
    check({tag, "_done_cycle"}, n, 33);
    if (seen) begin
      done_at = cyc;
      check({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
    end
    pop_check(tag);
  endtask

  initial begin
    int t1;
    int t2;
    int nd;
    int ns;
    rst = 1'b1; srca = '0; srcb = '0; aluctl = 3'b000;

    @(negedge clk);
    check("rst_res", aluresult, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_muldone", {31'd0, muldone}, 32'd0);
    @(posedge clk); #1;
    aluctl = 3'b101; srca = 32'd6; srcb = 32'd7;
    @(negedge clk);
    check("rst_mul_stall", {31'd0, stall}, 32'd0);
    check("rst_mul_res", aluresult, 32'd0);
    check("rst_mul_zero", {31'd0, zero}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; aluctl = 3'b000;

    do_op("add", 3'b010, 32'd7, 32'd5);
    do_op("sub", 3'b100, 32'd5, 32'd5);
    do_op("slt_neg", 3'b110, 32'hFFFF_FFFF, 32'd1);
    do_op("slt_pos", 3'b110, 32'd1, 32'hFFFF_FFFF);
    do_op("and", 3'b000, 32'h0000_F0F0, 32'h0000_FF00);
    do_op("or", 3'b001, 32'h0000_00F0, 32'h0000_000F);
    do_op("op011", 3'b011, 32'd3, 32'd4);
    do_op("op111", 3'b111, 32'd3, 32'd4);

    do_mul("mul6x7", 32'd6, 32'd7, 1'b0, t1);
    do_op("after_mul", 3'b010, 32'd10, 32'd20);
    do_mul("mul_neg", 32'hFFFF_FFFD, 32'd5, 1'b0, t1);
    do_mul("mul_wrap", 32'h0001_0000, 32'h0001_0000, 1'b0, t1);
    do_mul("mul_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, t1);
    do_mul("mul_scr", 32'd3, 32'd4, 1'b1, t1);

    do_mul("b2b_a", 32'd2, 32'd3, 1'b0, t1);
    do_mul("b2b_b", 32'd4, 32'd5, 1'b0, t2);
    check("b2b_gap", t2 - t1, 34);

    // Abort a multiply partway through BUSY.
    @(posedge clk); #1;
    srca = 32'd9; srcb = 32'd9; aluctl = 3'b101;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_stall", {31'd0, stall}, 32'd0);
    check("abort_muldone", {31'd0, muldone}, 32'd0);
    check("abort_res", aluresult, 32'd0);
    @(posedge clk); #1;
    aluctl = 3'b010; srca = 32'd3; srcb = 32'd4;
    @(negedge clk);
    check("rst_add", aluresult, 32'd7);
    @(posedge clk); #1;
    rst = 1'b0; srca = 32'd1; srcb = 32'd1; aluctl = 3'b010;
    #1;
    check("post_rst_add", aluresult, 32'd2);
    check("post_rst_stall", {31'd0, stall}, 32'd0);
    nd = 0; ns = 0;
    repeat (40) begin
      @(negedge clk);
      if (muldone) nd++;
      if (stall) ns++;
    end
    check("no_done_after_abort", nd, 0);
    check("no_stall_after_abort", ns, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
